// File: rtl/rom_loader_pkg.sv
// Shared state encoding and framing constants for the boot ROM loader.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // States in which the loader is still consuming the byte stream.
    function automatic logic is_active(input state_t s);
        return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input, ROM write port and boot status of the loader, bundled as one interface.
interface rom_loader_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          wen;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          core_rstn;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, wen, w_addr, w_data, core_rstn, busy, done, err
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, wen, w_addr, w_data, core_rstn, busy, done, err
    );
endinterface

// File: rtl/rom_loader_word_assembler.sv
// Collects four stream bytes into one little-endian 32-bit word; the word is
// presented combinationally together with its 4th byte.
module rom_loader_word_assembler
    import rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        i_clr,
    input  logic        i_byte_fire,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [BYTE_CNT_W-1:0] r_cnt;
    logic [23:0]           r_low;
    logic                  w_last;

    assign w_last       = (r_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign o_word       = {i_byte, r_low};
    assign o_word_valid = i_byte_fire & w_last;

    // The top byte is never stored; it completes the word in the cycle it arrives.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
            r_low <= '0;
        end else if (i_byte_fire) begin
            r_cnt <= r_cnt + 1'b1;
            case (r_cnt)
                2'd0:    r_low[7:0]   <= i_byte;
                2'd1:    r_low[15:8]  <= i_byte;
                2'd2:    r_low[23:16] <= i_byte;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Boot-time instruction ROM loader: header word count, N data words, XOR checksum;
// releases the core from reset only after a verified image.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int            DW        = 32,
    parameter int            AW        = 32,
    parameter int            MEM_NUM   = 4096,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rstn,
    rom_loader_if.master  io_bus
);

    localparam int IDX_W = $clog2(MEM_NUM + 1);

    state_t          r_state;
    state_t          w_next;
    logic [IDX_W-1:0] r_n;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]     r_csum;
    logic            r_ready;
    logic            r_wen;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;
    logic            r_core_rstn;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_fire;
    logic            w_clr;
    logic [31:0]     w_word;
    logic            w_word_valid;
    logic            w_hdr_bad;
    logic            w_last_word;

    assign w_fire      = io_bus.byte_valid & r_ready;
    assign w_clr       = ~rstn | ~is_active(r_state);
    assign w_hdr_bad   = (w_word == '0) || (w_word > 32'(MEM_NUM));
    assign w_last_word = (r_idx == r_n - 1'b1);

    rom_loader_word_assembler u_asm (
        .clk          (clk),
        .i_clr        (w_clr),
        .i_byte_fire  (w_fire),
        .i_byte       (io_bus.byte_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HDR:  if (w_word_valid) w_next = w_hdr_bad ? ST_ERR : ST_DATA;
            ST_DATA: if (w_word_valid && w_last_word) w_next = ST_CSUM;
            ST_CSUM: if (w_word_valid) w_next = (w_word == r_csum) ? ST_DONE : ST_ERR;
            default: w_next = r_state;
        endcase
    end

    // Status flags follow the next state so they change together with the state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_n         <= '0;
            r_idx       <= '0;
            r_csum      <= '0;
            r_ready     <= 1'b0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_core_rstn <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ready     <= is_active(w_next);
            r_busy      <= (w_next == ST_DATA) || (w_next == ST_CSUM);
            r_done      <= (w_next == ST_DONE);
            r_core_rstn <= (w_next == ST_DONE);
            r_err       <= (w_next == ST_ERR);
            r_wen       <= 1'b0;

            if (r_state == ST_HDR && w_word_valid && !w_hdr_bad) begin
                r_n <= w_word[IDX_W-1:0];
            end

            if (r_state == ST_DATA && w_word_valid) begin
                r_wen   <= 1'b1;
                r_waddr <= BASE_ADDR + (AW'(r_idx) << 2);
                r_wdata <= w_word;
                r_csum  <= r_csum ^ w_word;
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

    assign io_bus.byte_ready = r_ready;
    assign io_bus.wen        = r_wen;
    assign io_bus.w_addr     = r_waddr;
    assign io_bus.w_data     = r_wdata;
    assign io_bus.core_rstn  = r_core_rstn;
    assign io_bus.busy       = r_busy;
    assign io_bus.done       = r_done;
    assign io_bus.err        = r_err;

endmodule
